// File: rtl/layer_out_serializer.sv
// Captures one parallel layer output vector and replays it as a serial
// word stream (neuron 0 first) with ready back-pressure, back-to-back
// vector chaining and sticky overflow / valid-mismatch debug flags.
module layer_out_serializer #(
  parameter int unsigned NN        = 6,
  parameter int unsigned dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             i_valid,
  input  logic [NN*dataWidth-1:0]   i_data,
  input  logic                      o_ready,
  output logic                      o_valid,
  output logic [dataWidth-1:0]      o_data,
  output logic                      o_last,
  output logic                      busy,
  output logic                      overflow,
  output logic                      err_mismatch
);

  localparam int unsigned IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [dataWidth-1:0] buf_q [NN];
  logic [dataWidth-1:0] buf_d [NN];
  logic                 ovf_d, mis_d;
  logic                 capture;
  logic                 xfer;
  logic                 final_xfer;
  logic                 valid_d, last_d;
  logic [dataWidth-1:0] data_d;

  // Next-state, buffer load, sticky flags and next registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    ovf_d      = overflow;
    mis_d      = err_mismatch;
    capture    = 1'b0;
    xfer       = o_valid & o_ready;
    final_xfer = xfer && (idx_q == LAST_IDX);

    case (state_q)
      IDLE: begin
        if (i_valid[0]) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (final_xfer) begin
          if (i_valid[0]) begin
            // New vector chains directly behind the last word.
            capture = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          idx_d = idx_q + IDX_W'(1);
        end
        if (i_valid[0] && !final_xfer) begin
          ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (capture) begin
      for (int unsigned k = 0; k < NN; k++) begin
        buf_d[k] = i_data[k*dataWidth +: dataWidth];
      end
      if (!(&i_valid)) begin
        mis_d = 1'b1;
      end
    end

    valid_d = (state_d == SEND);
    data_d  = valid_d ? buf_d[idx_d] : '0;
    last_d  = valid_d && (idx_d == LAST_IDX);
  end

  // State, index, buffer, flags and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      for (int unsigned k = 0; k < NN; k++) begin
        buf_q[k] <= '0;
      end
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_last       <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
      err_mismatch <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      o_valid      <= valid_d;
      o_data       <= data_d;
      o_last       <= last_d;
      busy         <= valid_d;
      overflow     <= ovf_d;
      err_mismatch <= mis_d;
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer with a word scoreboard.
module tb_layer_out_serializer;

  localparam int unsigned NN = 6;
  localparam int unsigned DW = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NN-1:0]       i_valid = '0;
  logic [NN*DW-1:0]    i_data = '0;
  logic                o_ready = 1'b1;
  logic                o_valid;
  logic [DW-1:0]       o_data;
  logic                o_last;
  logic                busy;
  logic                overflow;
  logic                err_mismatch;

  int checks = 0;
  int errors = 0;
  logic [DW:0] sb [$];
  logic [DW:0] held;

  layer_out_serializer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .busy(busy), .overflow(overflow), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN*DW-1:0] vec(input logic [DW-1:0] base);
    logic [NN*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NN; k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  task automatic push_vec(input logic [DW-1:0] base);
    for (int k = 0; k < NN; k++) sb.push_back({(k == NN - 1), base + DW'(k)});
  endtask

  // Score the word handed over at the coming edge, then advance one cycle.
  task automatic tick();
    logic [DW:0] exp;
    if (o_valid && o_ready) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("word", {15'b0, o_last, o_data}, {15'b0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [NN-1:0] v, input logic [DW-1:0] base);
    i_valid = v;
    i_data  = vec(base);
    push_vec(base);
    tick();
    i_valid = '0;
    i_data  = $urandom();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      i_valid = NN'($urandom());
      i_data  = {$urandom(), $urandom(), $urandom()};
      o_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_outs", {9'b0, o_valid, o_data, o_last, busy, overflow, err_mismatch}, 32'h0);
    end
    sb.delete();
    rst     = 1'b0;
    i_valid = '0;
    o_ready = 1'b1;
  endtask

  initial begin
    logic rdy_pat [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // 1. reset with random inputs
    #1;
    do_reset(3);
    tick();
    chk("idle_after_reset", {31'b0, o_valid}, 32'h0);

    // 2. nominal stream
    capture(6'h3F, 16'h0001);
    for (int k = 0; k < NN; k++) begin
      chk("nom_valid", {30'b0, o_valid, busy}, 32'h3);
      tick();
    end
    chk("nom_done", {30'b0, o_valid, busy}, 32'h0);
    chk("nom_sb_empty", 32'(sb.size()), 32'h0);

    // 3. back-pressure
    capture(6'h3F, 16'h0001);
    for (int c = 0; c < 9; c++) begin
      o_ready = rdy_pat[c];
      held = {o_last, o_data};
      tick();
      if (!rdy_pat[c]) chk("bp_hold", {15'b0, o_last, o_data}, {15'b0, held});
    end
    o_ready = 1'b1;
    chk("bp_done", {31'b0, o_valid}, 32'h0);
    chk("bp_sb_empty", 32'(sb.size()), 32'h0);

    // 4. overflow at index 2
    capture(6'h3F, 16'h0001);
    tick();
    tick();
    i_valid = 6'h3F;
    i_data  = vec(16'h00A0);
    tick();
    i_valid = '0;
    chk("ovf_set", {31'b0, overflow}, 32'h1);
    for (int k = 0; k < 3; k++) tick();
    chk("ovf_idle", {31'b0, o_valid}, 32'h0);
    chk("ovf_sticky", {31'b0, overflow}, 32'h1);
    chk("ovf_sb_empty", 32'(sb.size()), 32'h0);
    tick();
    chk("ovf_no_replay", {31'b0, o_valid}, 32'h0);

    // 5. back-to-back
    do_reset(1);
    capture(6'h3F, 16'h0001);
    for (int k = 0; k < NN - 1; k++) begin
      chk("b2b_valid", {31'b0, o_valid}, 32'h1);
      tick();
    end
    chk("b2b_valid_last", {31'b0, o_valid}, 32'h1);
    capture(6'h3F, 16'h0010);
    for (int k = 0; k < NN; k++) begin
      chk("b2b_valid2", {31'b0, o_valid}, 32'h1);
      tick();
    end
    chk("b2b_done", {31'b0, o_valid}, 32'h0);
    chk("b2b_no_ovf", {31'b0, overflow}, 32'h0);
    chk("b2b_sb_empty", 32'(sb.size()), 32'h0);

    // 6A. valid mismatch still streams
    capture(6'h1F, 16'h0021);
    chk("mis_flag", {31'b0, err_mismatch}, 32'h1);
    for (int k = 0; k < NN; k++) tick();
    chk("mis_done", {31'b0, o_valid}, 32'h0);
    chk("mis_sb_empty", 32'(sb.size()), 32'h0);

    // 6B. reset while word 2 is on the bus
    capture(6'h3F, 16'h0001);
    tick();
    chk("mid_word2", {16'b0, o_data}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_outs", {9'b0, o_valid, o_data, o_last, busy, overflow, err_mismatch}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_quiet", {31'b0, o_valid}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
